// File: rtl/bcd_counter_display.sv
// bcd_counter_display: N-digit BCD up/down counter with a prescaled count
// tick, sanitised preset load, wrap flag and registered active-low
// seven-segment drive (optional leading-zero blanking) for HEX0..HEX(DIGITS-1).
module bcd_counter_display #(
  parameter int DIGITS        = 4,
  parameter int TICK_DIV      = 50000000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc;
  logic                tick;
  logic [4*DIGITS-1:0] next_bcd;
  logic                wrap;
  logic                chain;
  logic [3:0]          cur;
  logic [4*DIGITS-1:0] load_clean;
  logic [3:0]          ld_nib;
  logic [DIGITS-1:0]   blank;
  logic                higher_zero;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign tick = en && (presc == LAST);

  // Prescaler: free-runs only while enabled, restarts on reset or load.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      presc <= '0;
    end else if (load) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // Ripple increment/decrement through the digit chain; chain surviving
  // past the top digit means every digit rolled over, i.e. a wrap.
  always_comb begin
    next_bcd = bcd;
    chain    = 1'b1;
    cur      = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      cur = bcd[4*k +: 4];
      if (chain) begin
        if (up) begin
          if (cur == 4'd9) begin
            next_bcd[4*k +: 4] = 4'd0;
          end else begin
            next_bcd[4*k +: 4] = cur + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (cur == 4'd0) begin
            next_bcd[4*k +: 4] = 4'd9;
          end else begin
            next_bcd[4*k +: 4] = cur - 4'd1;
            chain = 1'b0;
          end
        end
      end
    end
    wrap = chain;
  end

  // Force any non-decimal preset nibble to 0 so bcd always stays decimal.
  always_comb begin
    load_clean = '0;
    ld_nib     = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      ld_nib = load_val[4*k +: 4];
      load_clean[4*k +: 4] = (ld_nib > 4'd9) ? 4'd0 : ld_nib;
    end
  end

  // Count register and wrap flag, priority reset > load > tick > hold.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      bcd   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      bcd   <= load_clean;
      carry <= 1'b0;
    end else if (tick) begin
      bcd   <= next_bcd;
      carry <= wrap;
    end else begin
      carry <= 1'b0;
    end
  end

  // A digit above 0 is blanked when it and all higher digits are zero.
  always_comb begin
    blank       = '0;
    higher_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero & (bcd[4*k +: 4] == 4'd0);
      if (BLANK_LEADING && (k > 0)) begin
        blank[k] = higher_zero;
      end
    end
  end

  // Registered display drive, one cycle behind bcd; dark during reset.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      HEX <= '1;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        HEX[7*k +: 7] <= blank[k] ? 7'b1111111 : seg7(bcd[4*k +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_display.sv
// tb_bcd_counter_display: directed stimulus with a cycle-stamped scoreboard
// for a 4-digit counter with a divide-by-4 prescaler and blanking enabled.
module tb_bcd_counter_display;

  localparam int DIGITS = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  localparam int K_BCD   = 0;
  localparam int K_CARRY = 1;
  localparam int K_HEX   = 2;

  logic                CLOCK_50;
  logic                rst;
  logic                en;
  logic                up;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] bcd;
  logic                carry;
  logic [7*DIGITS-1:0] HEX;

  typedef struct {
    int          at;
    int          kind;
    logic [27:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   base;

  bcd_counter_display #(
    .DIGITS(DIGITS),
    .TICK_DIV(4),
    .BLANK_LEADING(1'b1)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .rst(rst),
    .en(en),
    .up(up),
    .load(load),
    .load_val(load_val),
    .bcd(bcd),
    .carry(carry),
    .HEX(HEX)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Count rising edges so expectations can be stamped with a target cycle.
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [15:0] lv);
    rst = r; en = e; up = u; load = l; load_val = lv;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pushExpect(input int at, input int kind, input logic [27:0] val);
    exp_t e;
    e.at = at; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [27:0] bcdOf(input int k);
    return 28'((k / 10) * 16 + (k % 10));
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [27:0] act;
    string       nm;
    case (e.kind)
      K_BCD:   begin act = 28'(bcd);   nm = "bcd";   end
      K_CARRY: begin act = 28'(carry); nm = "carry"; end
      default: begin act = HEX;        nm = "HEX";   end
    endcase
    n_cmp++;
    if (act !== e.val) begin
      n_err++;
      $display("[TB] FAIL %s@cyc%0d: actual %h required %h", nm, e.at, act, e.val);
    end
  endtask

  // Monitor: on every falling edge, check and retire the entries due now.
  always @(negedge CLOCK_50) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL stale@cyc%0d: actual unchecked required kind %0d", sb[i].at, sb[i].kind);
        sb.delete(i);
      end
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(2);
    // Reset state, then first cycle after release.
    pushExpect(cyc, K_BCD, 28'h0);
    pushExpect(cyc, K_CARRY, 28'h0);
    pushExpect(cyc, K_HEX, 28'hFFFFFFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    pushExpect(cyc + 1, K_HEX, {BL, BL, BL, S0});
    pushExpect(cyc + 1, K_BCD, 28'h0);
    step(1);

    // Up count for 44 cycles: a tick every 4th edge.
    base = cyc;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int k = 1; k <= 11; k++) begin
      pushExpect(base + 4*k - 1, K_BCD, bcdOf(k - 1));
      pushExpect(base + 4*k,     K_BCD, bcdOf(k));
    end
    pushExpect(base + 4,  K_CARRY, 28'h0);
    pushExpect(base + 40, K_HEX, {BL, BL, BL, S9});
    pushExpect(base + 41, K_HEX, {BL, BL, S1, S0});
    step(44);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);

    // Wrap up from 9999.
    base = cyc;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h9999);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    pushExpect(base + 1, K_BCD, 28'h9999);
    pushExpect(base + 2, K_HEX, {S9, S9, S9, S9});
    pushExpect(base + 4, K_BCD, 28'h9999);
    pushExpect(base + 4, K_CARRY, 28'h0);
    pushExpect(base + 5, K_BCD, 28'h0000);
    pushExpect(base + 5, K_CARRY, 28'h1);
    pushExpect(base + 6, K_CARRY, 28'h0);
    pushExpect(base + 6, K_HEX, {BL, BL, BL, S0});
    step(4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(2);

    // Wrap down from 0000.
    base = cyc;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    pushExpect(base + 1, K_BCD, 28'h0000);
    pushExpect(base + 2, K_HEX, {BL, BL, BL, S0});
    pushExpect(base + 4, K_BCD, 28'h0000);
    pushExpect(base + 5, K_BCD, 28'h9999);
    pushExpect(base + 5, K_CARRY, 28'h1);
    pushExpect(base + 6, K_CARRY, 28'h0);
    pushExpect(base + 6, K_HEX, {S9, S9, S9, S9});
    step(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(2);

    // Load with tick in the same cycle, mid-period load, then enable freeze.
    base = cyc;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h3A7F);
    pushExpect(base + 3, K_BCD, 28'h9999);
    pushExpect(base + 4, K_BCD, 28'h3070);
    pushExpect(base + 4, K_CARRY, 28'h0);
    pushExpect(base + 5, K_HEX, {S3, S0, S7, S0});
    pushExpect(base + 6, K_BCD, 28'h3070);
    pushExpect(base + 7, K_BCD, 28'h0104);
    pushExpect(base + 8, K_BCD, 28'h0104);
    pushExpect(base + 14, K_BCD, 28'h0104);
    pushExpect(base + 20, K_BCD, 28'h0104);
    pushExpect(base + 21, K_BCD, 28'h0105);
    pushExpect(base + 22, K_HEX, {BL, S1, S0, S5});
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0104);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1);

    // Reset overrides a simultaneous load.
    base = cyc;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    pushExpect(base + 1, K_BCD, 28'h0000);
    pushExpect(base + 1, K_CARRY, 28'h0);
    pushExpect(base + 1, K_HEX, 28'hFFFFFFF);
    pushExpect(base + 2, K_HEX, {BL, BL, BL, S0});
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(2);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    while (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL timeout@cyc%0d: actual unchecked required kind %0d", sb[0].at, sb[0].kind);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
